// File: rtl/bram_burst_reader.sv
// Burst reader: streams len consecutive BRAM words from base_addr through a 2-entry skid buffer.
// Define BRAM_RDR_WRAP_EN to let the read address wrap past the top of the BRAM.
module bram_burst_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [ADDR_W+1:0] Depth = {2'b01, {ADDR_W{1'b0}}};

  state_t              state_q, state_d;
  logic                bramEn_q, bramEn_d;
  logic [ADDR_W-1:0]   bramAddr_q, bramAddr_d;
  logic                rdPend_q;
  logic [ADDR_W:0]     readsLeft_q, readsLeft_d;
  logic [ADDR_W:0]     wordsLeft_q, wordsLeft_d;
  logic [DATA_W-1:0]   skid_q [2];
  logic [DATA_W-1:0]   skid_d [2];
  logic [1:0]          cnt_q, cnt_d;
  logic                wrPtr_q, wrPtr_d;
  logic                rdPtr_q, rdPtr_d;

  logic lenOk;
  logic mValid, pop, popBuf, push, lastWord, room;
  logic doneD, errD;

`ifdef BRAM_RDR_WRAP_EN
  assign lenOk = (len != '0) && ({1'b0, len} <= Depth);
`else
  logic [ADDR_W+1:0] endAddr;
  assign endAddr = {2'b00, base_addr} + {1'b0, len};
  assign lenOk   = (len != '0) && (endAddr <= Depth);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bramEn_q    <= 1'b0;
      bramAddr_q  <= '0;
      rdPend_q    <= 1'b0;
      readsLeft_q <= '0;
      wordsLeft_q <= '0;
      skid_q      <= '{default: '0};
      cnt_q       <= '0;
      wrPtr_q     <= 1'b0;
      rdPtr_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bramEn_q    <= bramEn_d;
      bramAddr_q  <= bramAddr_d;
      rdPend_q    <= bramEn_q;
      readsLeft_q <= readsLeft_d;
      wordsLeft_q <= wordsLeft_d;
      skid_q      <= skid_d;
      cnt_q       <= cnt_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
    end
  end

  // A returning word bypasses the buffer only when the buffer is empty and the sink takes it now.
  always_comb begin
    state_d     = state_q;
    bramEn_d    = 1'b0;
    bramAddr_d  = bramAddr_q;
    readsLeft_d = readsLeft_q;
    wordsLeft_d = wordsLeft_q;
    skid_d      = skid_q;
    doneD       = 1'b0;
    errD        = 1'b0;

    mValid   = (cnt_q != 2'd0) || rdPend_q;
    pop      = mValid && m_ready;
    lastWord = (wordsLeft_q == (ADDR_W+1)'(1));
    popBuf   = pop && (cnt_q != 2'd0);
    push     = rdPend_q && !(pop && (cnt_q == 2'd0));

    if (push) skid_d[wrPtr_q] = bram_dout;
    wrPtr_d = wrPtr_q ^ push;
    rdPtr_d = rdPtr_q ^ popBuf;
    cnt_d   = cnt_q + {1'b0, push} - {1'b0, popBuf};
    if (pop) wordsLeft_d = wordsLeft_q - (ADDR_W+1)'(1);

    room = (({1'b0, bramEn_q} + cnt_d) < 2'd2);

    case (state_q)
      IDLE: begin
        if (start && !rst) begin
          if (lenOk) begin
            state_d     = RUN;
            bramEn_d    = 1'b1;
            bramAddr_d  = base_addr;
            readsLeft_d = len - (ADDR_W+1)'(1);
            wordsLeft_d = len;
          end else begin
            errD = 1'b1;
          end
        end
      end
      RUN: begin
        if ((readsLeft_q != '0) && room) begin
          bramEn_d    = 1'b1;
          bramAddr_d  = bramAddr_q + ADDR_W'(1);
          readsLeft_d = readsLeft_q - (ADDR_W+1)'(1);
        end
        if (bramEn_q && (readsLeft_q == '0)) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && lastWord) begin
          state_d = IDLE;
          doneD   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = doneD && !rst;
  assign err       = errD;
  assign bram_en   = bramEn_q;
  assign bram_addr = bramAddr_q;
  assign m_valid   = mValid;
  assign m_last    = mValid && lastWord;
  assign m_data    = (cnt_q != 2'd0) ? skid_q[rdPtr_q] : (rdPend_q ? bram_dout : '0);

endmodule

// File: doc/bram_burst_reader.md
BRAM_BURST_READER -- requirements
Module: bram_burst_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of BRAM read data and stream data.
REQ-002 SHALL have parameter ADDR_W, default 14: BRAM word-address width (16384 words).
REQ-003 SHALL have port clk, input, 1: single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: burst request, sampled only in IDLE.
REQ-006 SHALL have port base_addr, input, ADDR_W: first word address of the burst.
REQ-007 SHALL have port len, input, ADDR_W+1: burst length in words, legal range 1..16384.
REQ-008 SHALL have port busy, output, 1: high while the FSM is not in IDLE.
REQ-009 SHALL have port done, output, 1: one-cycle pulse when a burst completes.
REQ-010 SHALL have port err, output, 1: one-cycle pulse when a start is rejected.
REQ-011 SHALL have port bram_en, output, 1: read issue strobe to the BRAM port.
REQ-012 SHALL have port bram_addr, output, ADDR_W: BRAM read address.
REQ-013 SHALL have port bram_dout, input, DATA_W: BRAM read data, valid exactly 1 cycle after the issuing bram_en.
REQ-014 SHALL have port m_data, output, DATA_W: stream data.
REQ-015 SHALL have port m_valid, output, 1: stream data valid.
REQ-016 SHALL have port m_ready, input, 1: stream sink ready.
REQ-017 SHALL have port m_last, output, 1: marks the final word of the burst, qualified by m_valid.

Function
REQ-018 SHALL implement FSM states IDLE, RUN and DRAIN.
REQ-019 IDLE->RUN SHALL occur when start=1 and the burst is legal; base_addr and len are latched on that cycle.
REQ-020 RUN->DRAIN SHALL occur on the cycle the len-th read is issued.
REQ-021 DRAIN->IDLE SHALL occur on the cycle the last word is accepted (m_valid & m_ready & m_last); done pulses that same cycle.
REQ-022 start while busy=1 SHALL be ignored, with no err pulse.
REQ-023 len=0 at start SHALL pulse err for one cycle and leave the FSM in IDLE.
REQ-024 Reads SHALL be issued at incrementing addresses from base_addr, one per bram_en cycle.
REQ-025 bram_en SHALL be registered; for start accepted in cycle 0, the first bram_en is in cycle 1 and the first m_valid is in cycle 2.
REQ-026 A 2-entry skid buffer SHALL hold returned data. A read SHALL be issued only if (outstanding reads + buffered words) < 2 after the current cycle's pop.
REQ-027 No returned word SHALL ever be dropped or reordered.
REQ-028 With m_ready held at 1, throughput SHALL be one word per cycle after the first word.
REQ-029 m_data and m_last SHALL be held stable while m_valid=1 and m_ready=0.
REQ-030 m_last SHALL be high only on the len-th word.
REQ-031 bram_addr SHALL hold its last value when bram_en=0.

Reset
REQ-032 rst=1 SHALL force IDLE and clear the buffer and outstanding count. Outputs SHALL read busy=0, done=0, err=0, bram_en=0, bram_addr=0, m_valid=0, m_last=0, m_data=0.
REQ-033 rst asserted mid-burst SHALL abort the burst with no done pulse. Any BRAM data returning on the cycle after reset SHALL be discarded.

Configuration
REQ-034 Macro BRAM_RDR_WRAP_EN defined: read address SHALL wrap from 2^ADDR_W-1 to 0, and every len 1..16384 is legal.
REQ-035 Macro BRAM_RDR_WRAP_EN undefined: start with base_addr+len > 2^ADDR_W SHALL pulse err and stay in IDLE.

Verification
REQ-036 base_addr=0x0010, len=4, m_ready=1, mem[k]=k -> m_data 0x10,0x11,0x12,0x13 in cycles 2-5; m_last in cycle 5; done in cycle 5.
REQ-037 len=8, m_ready toggling 1,0,1,0 -> all 8 words delivered in order; data stable during stalls; never more than 2 reads in flight or buffered.
REQ-038 len=0 -> err pulses 1 cycle, busy stays 0, no bram_en. Second start during a len=16 burst -> ignored, no err.
REQ-039 base_addr=0x3FFE, len=4 -> with BRAM_RDR_WRAP_EN, addresses 0x3FFE,0x3FFF,0x0000,0x0001; without it, err pulse and no reads.
REQ-040 rst=1 after 3 words of a len=10 burst with m_ready=0 -> next cycle all outputs at reset values, no done pulse; a new len=2 burst then completes normally.
